// File: rtl/detector_notas_pkg.sv
// Shared definitions for the music-box note detector: note period table, note indices,
// FSM state encoding and default tuning values.
package detector_notas_pkg;

    localparam int PW_DEFAULT        = 16;
    localparam int TOL_SHIFT_DEFAULT = 6;
    localparam int STABLE_N_DEFAULT  = 3;
    localparam int TIMEOUT_DEFAULT   = 60000;
    localparam int NUM_NOTES         = 8;

    localparam logic [2:0] NOTE_C4 = 3'd0;
    localparam logic [2:0] NOTE_D4 = 3'd1;
    localparam logic [2:0] NOTE_E4 = 3'd2;
    localparam logic [2:0] NOTE_F4 = 3'd3;
    localparam logic [2:0] NOTE_G4 = 3'd4;
    localparam logic [2:0] NOTE_A4 = 3'd5;
    localparam logic [2:0] NOTE_B4 = 3'd6;
    localparam logic [2:0] NOTE_C5 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_SEARCH  = 2'd2,
        ST_DECIDE  = 2'd3
    } state_t;

    // Full square-wave periods in 12 MHz clock cycles; the sequencer toggles at half these.
    function automatic logic [15:0] note_period(input logic [2:0] idx);
        case (idx)
            NOTE_C4: return 16'd45867;
            NOTE_D4: return 16'd40863;
            NOTE_E4: return 16'd36405;
            NOTE_F4: return 16'd34362;
            NOTE_G4: return 16'd30612;
            NOTE_A4: return 16'd27273;
            NOTE_B4: return 16'd24297;
            NOTE_C5: return 16'd22934;
            default: return 16'd22934;
        endcase
    endfunction

endpackage

// File: rtl/detector_notas_sync_flanco.sv
// Brings the asynchronous note pin into the clock domain and flags each rising edge
// with a single-cycle pulse.
module sync_flanco (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pulse
);

    logic [2:0] shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
        end else begin
            shift <= {shift[1:0], pin};
        end
    end

    // The first two stages resolve metastability; the third remembers the previous level.
    assign pulse = shift[1] & ~shift[2];

endmodule

// File: rtl/detector_notas.sv
// Measures the period of the incoming note square wave and decodes it to a note index,
// reporting a note only after it has been seen on several consecutive periods.
module detector_notas
    import detector_notas_pkg::*;
#(
    parameter int TOL_SHIFT = TOL_SHIFT_DEFAULT,
    parameter int STABLE_N  = STABLE_N_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    parameter int PW        = PW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          square_wave,
    output logic [PW-1:0] period,
    output logic [2:0]    note,
    output logic          note_valid,
    output logic          note_stb,
    output logic          silence
);

    localparam int            CW          = (STABLE_N > 1) ? $clog2(STABLE_N + 1) : 1;
    localparam logic [CW-1:0] RUN_MAX     = CW'(STABLE_N);
    localparam logic [PW-1:0] CNT_MAX     = '1;
    localparam logic [PW-1:0] CNT_TIMEOUT = PW'(TIMEOUT);

    logic          edge_pulse;
    logic [PW-1:0] cnt;
    logic [PW-1:0] p;
    state_t        state;
    logic [2:0]    idx;
    logic [2:0]    match_idx;
    logic          match_found;
    logic [2:0]    cand;
    logic          cand_valid;
    logic [CW-1:0] run_len;
    logic [CW-1:0] run_next;
    logic [PW:0]   ref_p;
    logic [PW:0]   diff;
    logic [PW:0]   tol;
    logic          hit;
    logic          same;
    logic          promote;

    sync_flanco u_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (square_wave),
        .pulse (edge_pulse)
    );

    // Free-running period counter, restarted on every edge whatever the FSM is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (edge_pulse) begin
            cnt <= PW'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + PW'(1);
        end
    end

    always_comb begin
        ref_p    = (PW + 1)'(note_period(idx));
        diff     = ({1'b0, p} >= ref_p) ? ({1'b0, p} - ref_p) : (ref_p - {1'b0, p});
        tol      = ref_p >> TOL_SHIFT;
        hit      = (diff <= tol);
        same     = cand_valid && (match_idx == cand);
        run_next = !same ? CW'(1)
                 : (run_len == RUN_MAX) ? RUN_MAX
                 : run_len + CW'(1);
        promote  = match_found && (run_next == RUN_MAX) && (!note_valid || (note != match_idx));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            period      <= '0;
            p           <= '0;
            idx         <= '0;
            match_idx   <= '0;
            match_found <= 1'b0;
            cand        <= '0;
            cand_valid  <= 1'b0;
            run_len     <= '0;
            note        <= '0;
            note_valid  <= 1'b0;
            note_stb    <= 1'b0;
            silence     <= 1'b1;
        end else begin
            note_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    silence <= 1'b1;
                    if (edge_pulse) begin
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (edge_pulse) begin
                        period      <= cnt;
                        p           <= cnt;
                        idx         <= '0;
                        match_found <= 1'b0;
                        silence     <= 1'b0;
                        state       <= ST_SEARCH;
                    end else if (cnt == CNT_TIMEOUT) begin
                        silence    <= 1'b1;
                        note_valid <= 1'b0;
                        cand_valid <= 1'b0;
                        run_len    <= '0;
                        state      <= ST_IDLE;
                    end
                end
                // One table entry per cycle; the first hit is kept so the lowest index wins.
                ST_SEARCH: begin
                    if (hit && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (idx == 3'(NUM_NOTES - 1)) begin
                        state <= ST_DECIDE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_DECIDE: begin
                    if (!match_found) begin
                        note_valid <= 1'b0;
                        cand_valid <= 1'b0;
                        run_len    <= '0;
                    end else begin
                        cand       <= match_idx;
                        cand_valid <= 1'b1;
                        run_len    <= run_next;
                        if (promote) begin
                            note       <= match_idx;
                            note_valid <= 1'b1;
                            note_stb   <= 1'b1;
                        end
                    end
                    state <= ST_MEASURE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_detector_notas.sv
// Scenario bench for detector_notas: expected per-edge observations are queued as each
// edge is driven and compared once the decode for that edge has had time to settle.
module tb_detector_notas;

    typedef struct packed {
        logic [15:0] period;
        logic [2:0]  note;
        logic        valid;
        logic        silence;
        logic [3:0]  stbs;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        square_wave = 1'b0;
    logic [15:0] period;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_stb;
    logic        silence;

    int   compared = 0;
    int   mismatched = 0;
    int   stb_count = 0;
    int   stb_mark = 0;
    int   valid_drops = 0;
    bit   watch_valid = 1'b0;
    obs_t exp_q[$];

    detector_notas dut (
        .clk         (clk),
        .rst         (rst),
        .square_wave (square_wave),
        .period      (period),
        .note        (note),
        .note_valid  (note_valid),
        .note_stb    (note_stb),
        .silence     (silence)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_stb === 1'b1) stb_count++;
        if (watch_valid && note_valid !== 1'b1) valid_drops++;
    end

    function automatic obs_t mk(input int per, input int nt, input int v, input int s, input int n);
        obs_t o;
        o.period  = 16'(per);
        o.note    = 3'(nt);
        o.valid   = 1'(v);
        o.silence = 1'(s);
        o.stbs    = 4'(n);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("period=%0d note=%0d valid=%0d silence=%0d strobes=%0d",
                         o.period, o.note, o.valid, o.silence, o.stbs);
    endfunction

    task automatic sample(output obs_t o);
        o.period  = period;
        o.note    = note;
        o.valid   = note_valid;
        o.silence = silence;
        o.stbs    = 4'(stb_count - stb_mark);
        stb_mark  = stb_count;
    endtask

    // Next rising edge lands exactly gap cycles after the previous one; sampled 20 cycles later.
    task automatic rise_after(input int gap, output obs_t o);
        repeat (gap / 2 - 20) @(negedge clk);
        square_wave = 1'b0;
        repeat (gap - gap / 2) @(negedge clk);
        square_wave = 1'b1;
        repeat (20) @(negedge clk);
        sample(o);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k % 3 == 0) square_wave = ~square_wave;
            compared++;
            if ({period, note, note_valid, note_stb, silence} !== {16'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
                mismatched++;
                $display("[TB] FAIL reset_hold[%0d]: got period=%0d note=%0d valid=%0d stb=%0d silence=%0d required 0 0 0 0 1",
                         k, period, note, note_valid, note_stb, silence);
            end
        end
        square_wave = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        stb_mark = stb_count;
    endtask

    task automatic test_a4_lock();
        int   tbl[5][6] = '{'{100,   0,     0, 0, 1, 0},
                            '{27273, 27273, 0, 0, 0, 0},
                            '{27273, 27273, 0, 0, 0, 0},
                            '{27273, 27273, 5, 1, 0, 1},
                            '{27273, 27273, 5, 1, 0, 0}};
        obs_t got, want;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk(tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4], tbl[k][5]));
            rise_after(tbl[k][0], got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL a4_lock[%0d]: got %s required %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_mid_search();
        int   tbl[4][6] = '{'{100,   0,     0, 0, 1, 0},
                            '{27273, 27273, 0, 0, 0, 0},
                            '{27273, 27273, 0, 0, 0, 0},
                            '{27273, 27273, 5, 1, 0, 1}};
        obs_t got, want;
        repeat (27273 / 2 - 20) @(negedge clk);
        square_wave = 1'b0;
        repeat (27273 - 27273 / 2) @(negedge clk);
        square_wave = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        compared++;
        if ({period, note, note_valid, note_stb, silence} !== {16'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL mid_search_reset: got period=%0d note=%0d valid=%0d stb=%0d silence=%0d required 0 0 0 0 1",
                     period, note, note_valid, note_stb, silence);
        end
        repeat (20) @(negedge clk);
        square_wave = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 1, 0));
        sample(got);
        want = exp_q.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL reset_no_strobe: got %s required %s", fmt(got), fmt(want));
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4], tbl[k][5]));
            rise_after(tbl[k][0], got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL relock[%0d]: got %s required %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_note_change();
        int   tbl[3][6] = '{'{22934, 22934, 5, 1, 0, 0},
                            '{22934, 22934, 5, 1, 0, 0},
                            '{22934, 22934, 7, 1, 0, 1}};
        obs_t got, want;
        int   drops_before;
        drops_before = valid_drops;
        watch_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4], tbl[k][5]));
            rise_after(tbl[k][0], got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL note_change[%0d]: got %s required %s", k, fmt(got), fmt(want));
            end
        end
        watch_valid = 1'b0;
        compared++;
        if (valid_drops - drops_before != 0) begin
            mismatched++;
            $display("[TB] FAIL valid_held: got %0d low cycles required 0", valid_drops - drops_before);
        end
    endtask

    task automatic test_tolerance();
        int   tbl[4][6] = '{'{27700, 27700, 7, 0, 0, 0},
                            '{27699, 27699, 7, 0, 0, 0},
                            '{27699, 27699, 7, 0, 0, 0},
                            '{27699, 27699, 5, 1, 0, 1}};
        obs_t got, want;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4], tbl[k][5]));
            rise_after(tbl[k][0], got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL tolerance[%0d]: got %s required %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_timeout();
        obs_t got, want;
        repeat (10) @(negedge clk);
        square_wave = 1'b0;
        exp_q.push_back(mk(27699, 5, 1, 0, 0));
        repeat (59990 - 30) @(negedge clk);
        sample(got);
        want = exp_q.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL before_timeout: got %s required %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(27699, 5, 0, 1, 0));
        repeat (30) @(negedge clk);
        sample(got);
        want = exp_q.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL after_timeout: got %s required %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(27699, 5, 0, 1, 0));
        rise_after(100, got);
        want = exp_q.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL first_edge_after_silence: got %s required %s", fmt(got), fmt(want));
        end
    endtask

    initial begin
        test_reset();
        test_a4_lock();
        test_reset_mid_search();
        test_note_change();
        test_tolerance();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
